// File: rtl/task_issue_queue_pkg.sv
// Shared NPU task-queue definitions: descriptor width, class encodings and
// default queue sizing used by the issue queue and its FIFOs.
package task_issue_queue_pkg;

   localparam int NPU_TASK_W       = 16;
   localparam int NPU_QUEUE_DEPTH  = 16;
   localparam int NPU_STARVE_LIMIT = 8;

   typedef enum logic {
      PRIO_LO = 1'b0,
      PRIO_HI = 1'b1
   } task_prio_e;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_HI   = 2'd1,
      GRANT_LO   = 2'd2
   } grant_e;

endpackage

// File: rtl/task_issue_queue_if.sv
// Bundle of the decode-side push port, load-balancer issue port, flush and
// occupancy/status signals of the task issue queue.
interface task_issue_queue_if #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 5
);
   logic [DATA_W-1:0] in_data;
   logic              in_prio;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              flush;
   logic [CNT_W-1:0]  hi_count;
   logic [CNT_W-1:0]  lo_count;
   logic [15:0]       issued_cnt;

   modport master (
      output in_data, in_prio, in_valid, out_ready, flush,
      input  in_ready, out_data, out_valid, hi_count, lo_count, issued_cnt
   );

   modport slave (
      input  in_data, in_prio, in_valid, out_ready, flush,
      output in_ready, out_data, out_valid, hi_count, lo_count, issued_cnt
   );
endinterface

// File: rtl/task_issue_queue_sync_fifo_cnt.sv
// Single-clock FIFO with an occupancy count; full/empty come from the count,
// so pointers may wrap freely. Flush clears pointers and count.
module sync_fifo_cnt #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !flush && (count != CNT_W'(DEPTH));
   assign do_pop  = pop  && !flush && (count != '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/task_issue_queue.sv
// Two-class task issue queue: per-class FIFOs feeding a registered output
// stage, strict high priority bounded by an anti-starvation grant limit.
module task_issue_queue
   import task_issue_queue_pkg::*;
#(
   parameter int DATA_W       = NPU_TASK_W,
   parameter int DEPTH        = NPU_QUEUE_DEPTH,
   parameter int STARVE_LIMIT = NPU_STARVE_LIMIT
) (
   input logic              clk,
   input logic              rst_n,
   task_issue_queue_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0]  hi_count;
   logic [CNT_W-1:0]  lo_count;
   logic [DATA_W-1:0] hi_rd_data;
   logic [DATA_W-1:0] lo_rd_data;
   logic              in_ready_c;
   logic              hi_push;
   logic              lo_push;
   logic              hi_avail;
   logic              lo_avail;
   logic              load_en;
   grant_e            grant;

   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic [15:0]       issued_q;
   logic [STV_W-1:0]  starve_cnt;

   // Readiness looks only at the requested class, so one full class never
   // blocks the other.
   assign in_ready_c = !bus.flush &&
                       ((bus.in_prio == PRIO_HI) ? (hi_count != CNT_W'(DEPTH))
                                                 : (lo_count != CNT_W'(DEPTH)));
   assign hi_push  = bus.in_valid && in_ready_c && (bus.in_prio == PRIO_HI);
   assign lo_push  = bus.in_valid && in_ready_c && (bus.in_prio == PRIO_LO);
   assign hi_avail = (hi_count != '0);
   assign lo_avail = (lo_count != '0);
   assign load_en  = (!out_valid_q || bus.out_ready) && (hi_avail || lo_avail);

   always_comb begin
      grant = GRANT_NONE;
      if (load_en) begin
         if (lo_avail && (!hi_avail || (starve_cnt == STV_W'(STARVE_LIMIT)))) begin
            grant = GRANT_LO;
         end else if (hi_avail) begin
            grant = GRANT_HI;
         end
      end
   end

   sync_fifo_cnt #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_hi_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (bus.flush),
      .push    (hi_push),
      .wr_data (bus.in_data),
      .pop     (grant == GRANT_HI),
      .rd_data (hi_rd_data),
      .count   (hi_count)
   );

   sync_fifo_cnt #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lo_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (bus.flush),
      .push    (lo_push),
      .wr_data (bus.in_data),
      .pop     (grant == GRANT_LO),
      .rd_data (lo_rd_data),
      .count   (lo_count)
   );

   // A handshake in the flush cycle still counts as issued; flush only
   // discards what is buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         issued_q    <= '0;
         starve_cnt  <= '0;
      end else begin
         if (out_valid_q && bus.out_ready) begin
            issued_q <= issued_q + 16'd1;
         end
         if (bus.flush) begin
            out_valid_q <= 1'b0;
            starve_cnt  <= '0;
         end else begin
            case (grant)
               GRANT_HI: begin
                  out_data_q  <= hi_rd_data;
                  out_valid_q <= 1'b1;
               end
               GRANT_LO: begin
                  out_data_q  <= lo_rd_data;
                  out_valid_q <= 1'b1;
               end
               default: begin
                  if (bus.out_ready) begin
                     out_valid_q <= 1'b0;
                  end
               end
            endcase
            if (!lo_avail || (grant == GRANT_LO)) begin
               starve_cnt <= '0;
            end else if (grant == GRANT_HI) begin
               starve_cnt <= starve_cnt + STV_W'(1);
            end
         end
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.hi_count   = hi_count;
   assign bus.lo_count   = lo_count;
   assign bus.issued_cnt = issued_q;

endmodule

// File: tb/tb_task_issue_queue.sv
// Directed bench for task_issue_queue: latency, full/backpressure, priority
// with starvation limit, pointer wrap, flush and asynchronous reset.
module tb_task_issue_queue;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   task_issue_queue_if #(.DATA_W(16), .CNT_W(5)) bus ();

   task_issue_queue #(.DATA_W(16), .DEPTH(16), .STARVE_LIMIT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic p);
      bus.in_data  = d;
      bus.in_prio  = p;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_data   = '0;
      bus.in_prio   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      #3;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0h exp=0", bus.out_valid); end
      checks++; if (bus.out_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_data got=%0h exp=0", bus.out_data); end
      checks++; if (bus.hi_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_hi got=%0d exp=0", bus.hi_count); end
      checks++; if (bus.lo_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_lo got=%0d exp=0", bus.lo_count); end
      checks++; if (bus.issued_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_issued got=%0d exp=0", bus.issued_cnt); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0h exp=1", bus.in_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bus.out_ready = 1'b1;
      push(16'h1234, 1'b0);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_valid got=%0h exp=0", bus.out_valid); end
      checks++; if (bus.lo_count !== 5'd1) begin failures++; $display("[TB] FAIL single_lo_count got=%0d exp=1", bus.lo_count); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%0h exp=1", bus.out_valid); end
      checks++; if (bus.out_data !== 16'h1234) begin failures++; $display("[TB] FAIL single_data got=%0h exp=1234", bus.out_data); end
      checks++; if (bus.lo_count !== 5'd0) begin failures++; $display("[TB] FAIL single_lo_drain got=%0d exp=0", bus.lo_count); end
      step();
      checks++; if (bus.issued_cnt !== 16'd1) begin failures++; $display("[TB] FAIL single_issued got=%0d exp=1", bus.issued_cnt); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_idle got=%0h exp=0", bus.out_valid); end
   endtask

   task automatic test_full();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(16'(16'hB000 + i), 1'b1);
      checks++; if (bus.hi_count !== 5'd15) begin failures++; $display("[TB] FAIL full_hi15 got=%0d exp=15", bus.hi_count); end
      push(16'hB010, 1'b1);
      checks++; if (bus.hi_count !== 5'd16) begin failures++; $display("[TB] FAIL full_hi16 got=%0d exp=16", bus.hi_count); end
      bus.in_prio = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_hi got=%0h exp=0", bus.in_ready); end
      bus.in_prio = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_lo got=%0h exp=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hB000) begin failures++; $display("[TB] FAIL full_hold got=%0h/%0h exp=1/b000", bus.out_valid, bus.out_data); end
      checks++; if (bus.issued_cnt !== 16'd1) begin failures++; $display("[TB] FAIL full_issued got=%0d exp=1", bus.issued_cnt); end
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      checks++; if (bus.hi_count !== 5'd0 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_flush got=%0d/%0h exp=0/0", bus.hi_count, bus.out_valid); end
   endtask

   task automatic test_priority();
      logic [15:0] exp_q [16];
      exp_q[0] = 16'h4FFF;
      for (int i = 0; i < 8; i++) exp_q[1 + i] = 16'(16'hA000 + i);
      exp_q[9] = 16'h5000;
      for (int i = 0; i < 4; i++) exp_q[10 + i] = 16'(16'hA008 + i);
      exp_q[14] = 16'h5001;
      exp_q[15] = 16'h5002;
      bus.out_ready = 1'b0;
      push(16'h4FFF, 1'b0);
      for (int i = 0; i < 12; i++) push(16'(16'hA000 + i), 1'b1);
      for (int i = 0; i < 3; i++) push(16'(16'h5000 + i), 1'b0);
      checks++; if (bus.hi_count !== 5'd12 || bus.lo_count !== 5'd3) begin failures++; $display("[TB] FAIL prio_preload got=%0d/%0d exp=12/3", bus.hi_count, bus.lo_count); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i]) begin failures++; $display("[TB] FAIL prio_order[%0d] got=%0h/%0h exp=1/%0h", i, bus.out_valid, bus.out_data, exp_q[i]); end
         step();
      end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL prio_drained got=%0h exp=0", bus.out_valid); end
      checks++; if (bus.issued_cnt !== 16'd17) begin failures++; $display("[TB] FAIL prio_issued got=%0d exp=17", bus.issued_cnt); end
   endtask

   task automatic test_wrap();
      bus.out_ready = 1'b1;
      bus.in_prio   = 1'b0;
      for (int i = 0; i <= 40; i++) begin
         bus.in_data  = 16'(16'h7000 + i);
         bus.in_valid = (i < 40);
         step();
         checks++; if (bus.lo_count !== ((i < 40) ? 5'd1 : 5'd0)) begin failures++; $display("[TB] FAIL wrap_count[%0d] got=%0d exp=%0d", i, bus.lo_count, (i < 40) ? 1 : 0); end
         if (i >= 1) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(16'h7000 + i - 1)) begin failures++; $display("[TB] FAIL wrap_data[%0d] got=%0h/%0h exp=1/%0h", i, bus.out_valid, bus.out_data, 16'(16'h7000 + i - 1)); end
         end
      end
      bus.in_valid = 1'b0;
      step();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_idle got=%0h exp=0", bus.out_valid); end
      checks++; if (bus.issued_cnt !== 16'd57) begin failures++; $display("[TB] FAIL wrap_issued got=%0d exp=57", bus.issued_cnt); end
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(16'(16'hC000 + i), 1'b1);
      for (int i = 0; i < 3; i++) push(16'(16'hD000 + i), 1'b0);
      checks++; if (bus.out_data !== 16'hC000 || bus.hi_count !== 5'd2 || bus.lo_count !== 5'd3) begin failures++; $display("[TB] FAIL flush_pre got=%0h/%0d/%0d exp=c000/2/3", bus.out_data, bus.hi_count, bus.lo_count); end
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_prio  = 1'b0;
      bus.in_data  = 16'hDEAD;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready got=%0h exp=0", bus.in_ready); end
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%0h exp=0", bus.out_valid); end
      checks++; if (bus.hi_count !== 5'd0 || bus.lo_count !== 5'd0) begin failures++; $display("[TB] FAIL flush_counts got=%0d/%0d exp=0/0", bus.hi_count, bus.lo_count); end
      checks++; if (bus.issued_cnt !== 16'd57) begin failures++; $display("[TB] FAIL flush_issued got=%0d exp=57", bus.issued_cnt); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready_after got=%0h exp=1", bus.in_ready); end
      push(16'h1111, 1'b1);
      step();
      bus.out_ready = 1'b1;
      bus.flush     = 1'b1;
      step();
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      checks++; if (bus.issued_cnt !== 16'd58 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_handshake got=%0d/%0h exp=58/0", bus.issued_cnt, bus.out_valid); end
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      push(16'h2222, 1'b0);
      step();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre_valid got=%0h exp=1", bus.out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin failures++; $display("[TB] FAIL arst_out got=%0h/%0h exp=0/0", bus.out_valid, bus.out_data); end
      checks++; if (bus.issued_cnt !== 16'd0) begin failures++; $display("[TB] FAIL arst_issued got=%0d exp=0", bus.issued_cnt); end
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      push(16'h3333, 1'b1);
      checks++; if (bus.out_valid !== 1'b0 || bus.hi_count !== 5'd1) begin failures++; $display("[TB] FAIL arst_accept got=%0h/%0d exp=0/1", bus.out_valid, bus.hi_count); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h3333) begin failures++; $display("[TB] FAIL arst_issue got=%0h/%0h exp=1/3333", bus.out_valid, bus.out_data); end
      step();
      checks++; if (bus.issued_cnt !== 16'd1) begin failures++; $display("[TB] FAIL arst_issued_after got=%0d exp=1", bus.issued_cnt); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single();
      test_full();
      test_priority();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/task_issue_queue.md
Name: task_issue_queue

Overview:
- Two-class (high/normal priority) task descriptor buffer directly upstream of the PE load balancer.
- Accepts 16-bit task descriptors from the command/decode stage and buffers them in per-class FIFOs.
- Arbitrates between the two FIFOs and presents one task at a time on a registered valid/ready output that drives the load balancer's task_data/task_valid/task_ready.
- Strict priority with an anti-starvation limit; supports synchronous flush and occupancy reporting.

Parameters:
- DATA_W, 16, task descriptor width.
- DEPTH, 16, entries per class FIFO; must be a power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive high-class grants allowed while the normal class is waiting.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  DATA_W  task descriptor from the decode stage.
- in_prio  input  1  class: 1 = high, 0 = normal.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  descriptor accepted when in_valid && in_ready at clk edge.
- out_data  output  DATA_W  to load balancer task_data.
- out_valid  output  1  to load balancer task_valid.
- out_ready  input  1  from load balancer task_ready.
- flush  input  1  synchronous clear of all buffered tasks.
- hi_count  output  CNT_W  high FIFO occupancy; excludes the output register.
- lo_count  output  CNT_W  normal FIFO occupancy; excludes the output register.
- issued_cnt  output  16  total tasks handed to the consumer; wraps at 65535 -> 0.

Behaviour:
- Reset (async, rst_n=0): both FIFOs empty, pointers 0, hi_count=lo_count=0, out_valid=0, out_data=0, issued_cnt=0, starvation counter=0.
- in_ready is combinational: !flush && (in_prio ? hi_count!=DEPTH : lo_count!=DEPTH).
  - It depends on in_prio.
  - A full FIFO of one class does not block the other class.
- Push: on in_valid && in_ready, in_data is written at the write pointer of the selected FIFO; the pointer advances modulo DEPTH.
- Output register loads when (!out_valid || (out_valid && out_ready)) and at least one FIFO is non-empty, using registered occupancy.
  - Otherwise it holds.
  - out_data must stay stable while out_valid=1 && out_ready=0.
- Latency: a task accepted at edge N into empty FIFOs with an empty output register is loaded at edge N+1; out_valid is high from N+1.
- Back-to-back: with out_ready held high and tasks available, one task issues per cycle.
- Arbitration, at each load:
  - Only one class non-empty: take it.
  - Both non-empty and starve_cnt < STARVE_LIMIT: take high and increment starve_cnt.
  - Both non-empty and starve_cnt == STARVE_LIMIT: take normal and clear starve_cnt.
  - Any normal grant, or lo_count==0, clears starve_cnt.
- Counts: a push and a pop of the same FIFO in one cycle leave its count unchanged. Counts never exceed DEPTH or underflow.
- Wrap-around: pointers wrap modulo DEPTH. Full/empty is taken from the counts, not from pointer equality.
- issued_cnt increments on every out_valid && out_ready edge.
- flush=1 at an edge has highest priority over simultaneous push and load:
  - Both FIFOs emptied, pointers and counts zeroed, out_valid=0, starve_cnt=0.
  - issued_cnt is not cleared; it still counts a handshake that completes in the flush cycle.
  - in_ready=0 during flush.
- Reset asserted mid-transfer discards all state immediately; out_valid falls asynchronously.
- No combinational path from out_ready to out_valid/out_data. in_ready depends only on in_prio, flush and registered state.

Decomposition:
- Shared package npu_definitions.vh gains:
  - NPU_TASK_W (16).
  - NPU_TASK_PRIO_HI/LO encodings.
  - Default queue depth and starvation constants.
- One sub-module, sync_fifo_cnt: a parameterised single-clock FIFO with count output, instantiated twice (hi, lo).
- Arbitration and the output register stay in the top module.

Test Plan:
- Reset, then push 0x1234 (prio 0) with out_ready=1 -> out_valid rises one cycle after acceptance, out_data=0x1234, issued_cnt=1, lo_count returns to 0.
- out_ready=0, push 16 high tasks -> the first moves to the output register, so hi_count reaches 15.
  - Push one more -> hi_count=16 and in_ready=0 for in_prio=1, while in_ready=1 for in_prio=0.
  - out_data holds the first task unchanged.
- Preload 12 high (0xA000..0xA00B) and 3 normal (0x5000..) tasks, out_ready=1 -> order: 8 high, 0x5000, 4 high (hi empty), then 0x5001, 0x5002.
- Wrap-around: 40 push/pop pairs through one FIFO with DEPTH=16 -> data order preserved, count never exceeds 16.
- Assert flush with 5 tasks buffered and out_valid=1 -> next cycle out_valid=0, hi_count=lo_count=0, in_ready=0 during flush, issued_cnt unchanged.
- Drop rst_n asynchronously mid-stream -> out_valid=0 immediately, issued_cnt=0. After release, a new push issues normally with two-edge latency.
